// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear controller for an mm:ss BCD counter chain.
// Divides clk into a once-per-TICK_DIV increment pulse gated by the FSM state,
// requests a one-cycle clear of the counters, saturates at 59:59 and freezes
// the display while a lap time is shown.
//
// Ports
//   clk         global clock
//   rst         asynchronous, active-high reset
//   start_stop  one-cycle pulse: toggle run/pause (beats lap_reset)
//   lap_reset   one-cycle pulse: lap freeze while running, clear while stopped
//   sec_cnt     live seconds BCD {tens,units}
//   min_cnt     live minutes BCD {tens,units}
//   inc_pulse   one-cycle increment to the seconds counter
//   clr_cnt     one-cycle load-zero request to both counters
//   disp_sec    seconds shown on the display (live or frozen)
//   disp_min    minutes shown on the display (live or frozen)
//   running     1 in RUN or LAP
//   frozen      1 in LAP
//   done        1 in FULL (59:59 reached)
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned TICK_W   = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap_reset,
  input  logic [7:0] sec_cnt,
  input  logic [7:0] min_cnt,
  output logic       inc_pulse,
  output logic       clr_cnt,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_min,
  output logic       running,
  output logic       frozen,
  output logic       done
);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [15:0]       TIME_MAX = 16'h5959;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    LAP,
    PAUSE,
    FULL
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;

  logic       inc_d, clr_d;
  logic       running_d, frozen_d, done_d;
  logic [7:0] disp_sec_d, disp_min_d;
  logic       tick, at_max;

  assign tick   = (presc_q == TICK_MAX);
  assign at_max = ({min_cnt, sec_cnt} == TIME_MAX);

  // State and prescaler registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // Next-state, prescaler and next-output decode
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    inc_d      = 1'b0;
    clr_d      = 1'b0;
    disp_sec_d = sec_cnt;
    disp_min_d = min_cnt;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (start_stop) begin
          state_d = RUN;
        end else if (lap_reset) begin
          clr_d = 1'b1;
        end
      end

      RUN, LAP: begin
        // A pause on the tick edge swallows the tick; the prescaler holds so
        // the pulse arrives one cycle after the resume.
        if (start_stop) begin
          state_d = PAUSE;
        end else begin
          if (lap_reset) begin
            state_d = (state_q == RUN) ? LAP : RUN;
          end
          if (tick) begin
            presc_d = '0;
            // Saturate at 59:59 instead of letting the counters wrap
            if (at_max) begin
              state_d = FULL;
            end else begin
              inc_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + TICK_W'(1);
          end
        end
      end

      PAUSE: begin
        if (start_stop) begin
          state_d = RUN;
        end else if (lap_reset) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          presc_d = '0;
        end
      end

      FULL: begin
        presc_d = '0;
        if (lap_reset) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase

    // Display is held for the whole time LAP is the current state
    if (state_q == LAP) begin
      disp_sec_d = disp_sec;
      disp_min_d = disp_min;
    end

    running_d = (state_d == RUN) || (state_d == LAP);
    frozen_d  = (state_d == LAP);
    done_d    = (state_d == FULL);
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_pulse <= 1'b0;
      clr_cnt   <= 1'b0;
      disp_sec  <= 8'h00;
      disp_min  <= 8'h00;
      running   <= 1'b0;
      frozen    <= 1'b0;
      done      <= 1'b0;
    end else begin
      inc_pulse <= inc_d;
      clr_cnt   <= clr_d;
      disp_sec  <= disp_sec_d;
      disp_min  <= disp_min_d;
      running   <= running_d;
      frozen    <= frozen_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with TICK_DIV=4. Stimulus queues the expected
// inc_pulse / clr_cnt events (kind + edge number); a forked monitor pops and
// compares them whenever the DUT raises either pulse.
module tb_stopwatch_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned TICK_W   = 3;
  localparam int K_INC = 0;
  localparam int K_CLR = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       lap_reset = 1'b0;
  logic [7:0] sec_cnt = 8'h00;
  logic [7:0] min_cnt = 8'h00;
  logic       inc_pulse, clr_cnt, running, frozen, done;
  logic [7:0] disp_sec, disp_min;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .lap_reset (lap_reset),
    .sec_cnt   (sec_cnt),
    .min_cnt   (min_cnt),
    .inc_pulse (inc_pulse),
    .clr_cnt   (clr_cnt),
    .disp_sec  (disp_sec),
    .disp_min  (disp_min),
    .running   (running),
    .frozen    (frozen),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the last rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    ev_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_pulse kind=%0d: expected at cycle %0d, not raised by cycle %0d", e.kind, e.at, cyc);
        end
        if (inc_pulse && clr_cnt) begin
          checks++;
          failures++;
          $display("FAIL inc_clr_overlap at cycle %0d: got both high expected at most one", cyc);
        end
        if (inc_pulse || clr_cnt) begin
          kind = inc_pulse ? K_INC : K_CLR;
          checks++;
          if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
              failures++;
              $display("FAIL pulse_kind at cycle %0d: got kind %0d expected kind %0d", cyc, kind, e.kind);
            end
          end else begin
            failures++;
            $display("FAIL unexpected_pulse at cycle %0d: got kind %0d expected none", cyc, kind);
          end
        end
      end
    end
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int r;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_inc", int'(inc_pulse), 0);
    chk("rst_clr", int'(clr_cnt), 0);
    chk("rst_status", int'({running, frozen, done}), 0);
    chk("rst_disp", int'({disp_min, disp_sec}), 0);
    rst = 1'b0;
    @(negedge clk);

    // IDLE lap_reset: single clear, stays idle
    lap_reset = 1'b1;
    expect_ev(K_CLR, cyc + 1);
    @(negedge clk);
    lap_reset = 1'b0;
    chk("idle_clr_running", int'(running), 0);
    repeat (6) @(negedge clk);
    chk("idle_stays_idle", int'({running, done}), 0);

    // Run 12 cycles: pulses 4, 8, 12 edges after accept
    start_stop = 1'b1;
    a = cyc + 1;
    expect_ev(K_INC, a + 4);
    expect_ev(K_INC, a + 8);
    expect_ev(K_INC, a + 12);
    @(negedge clk);
    start_stop = 1'b0;
    chk("run_running", int'(running), 1);
    tick_to(a + 12);
    // Pause two cycles after the pulse, wait, resume
    tick_to(a + 14);
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    chk("pause_running", int'(running), 0);
    repeat (10) @(negedge clk);
    start_stop = 1'b1;
    r = cyc + 1;
    expect_ev(K_INC, r + 2);
    @(negedge clk);
    start_stop = 1'b0;
    tick_to(r + 2);

    // start_stop and lap_reset together: start_stop wins
    start_stop = 1'b1;
    lap_reset  = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    chk("both_running", int'(running), 0);
    chk("both_frozen", int'(frozen), 0);
    chk("both_clr", int'(clr_cnt), 0);
    repeat (3) @(negedge clk);
    lap_reset = 1'b1;
    expect_ev(K_CLR, cyc + 1);
    @(negedge clk);
    lap_reset = 1'b0;
    chk("pause_clear_idle", int'(running), 0);
    repeat (5) @(negedge clk);

    // Pause on the tick edge: tick swallowed, pulse 1 edge after resume
    start_stop = 1'b1;
    a = cyc + 1;
    @(negedge clk);
    start_stop = 1'b0;
    tick_to(a + 3);
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    chk("tickpause_inc", int'(inc_pulse), 0);
    chk("tickpause_running", int'(running), 0);
    repeat (3) @(negedge clk);
    start_stop = 1'b1;
    r = cyc + 1;
    expect_ev(K_INC, r + 1);
    @(negedge clk);
    start_stop = 1'b0;
    tick_to(r + 1);
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    lap_reset = 1'b1;
    expect_ev(K_CLR, cyc + 1);
    @(negedge clk);
    lap_reset = 1'b0;

    // Lap freeze
    sec_cnt = 8'h12;
    repeat (2) @(negedge clk);
    start_stop = 1'b1;
    a = cyc + 1;
    expect_ev(K_INC, a + 4);
    expect_ev(K_INC, a + 8);
    @(negedge clk);
    start_stop = 1'b0;
    lap_reset = 1'b1;
    @(negedge clk);
    lap_reset = 1'b0;
    chk("lap_frozen", int'(frozen), 1);
    chk("lap_running", int'(running), 1);
    chk("lap_disp_latch", int'(disp_sec), 'h12);
    sec_cnt = 8'h15;
    @(negedge clk);
    chk("lap_disp_hold1", int'(disp_sec), 'h12);
    tick_to(a + 5);
    chk("lap_disp_hold2", int'(disp_sec), 'h12);
    lap_reset = 1'b1;
    @(negedge clk);
    lap_reset = 1'b0;
    chk("unlap_frozen", int'(frozen), 0);
    chk("unlap_running", int'(running), 1);
    @(negedge clk);
    chk("unlap_disp_live", int'(disp_sec), 'h15);
    tick_to(a + 8);
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    lap_reset = 1'b1;
    expect_ev(K_CLR, cyc + 1);
    @(negedge clk);
    lap_reset = 1'b0;
    chk("lap_end_idle", int'(running), 0);

    // Saturation at 59:59
    sec_cnt = 8'h59;
    min_cnt = 8'h59;
    repeat (2) @(negedge clk);
    start_stop = 1'b1;
    a = cyc + 1;
    @(negedge clk);
    start_stop = 1'b0;
    tick_to(a + 3);
    chk("full_pre_status", int'({running, done}), 'b10);
    chk("full_pre_disp", int'({disp_min, disp_sec}), 'h5959);
    @(negedge clk);
    chk("full_done", int'(done), 1);
    chk("full_running", int'(running), 0);
    chk("full_inc", int'(inc_pulse), 0);
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_ignores_ss", int'({running, done}), 'b01);
    lap_reset = 1'b1;
    expect_ev(K_CLR, cyc + 1);
    @(negedge clk);
    lap_reset = 1'b0;
    chk("full_clear_done", int'(done), 0);
    chk("full_clear_running", int'(running), 0);
    sec_cnt = 8'h00;
    min_cnt = 8'h00;

    // Asynchronous reset mid-RUN
    sec_cnt = 8'h34;
    min_cnt = 8'h12;
    repeat (2) @(negedge clk);
    start_stop = 1'b1;
    a = cyc + 1;
    expect_ev(K_INC, a + 4);
    @(negedge clk);
    start_stop = 1'b0;
    tick_to(a + 4);
    chk("pre_rst_inc", int'(inc_pulse), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_inc", int'(inc_pulse), 0);
    chk("async_rst_status", int'({running, frozen, done}), 0);
    chk("async_rst_disp", int'({disp_min, disp_sec}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", int'(running), 0);
    chk("post_rst_disp_live", int'({disp_min, disp_sec}), 'h1234);
    start_stop = 1'b1;
    a = cyc + 1;
    expect_ev(K_INC, a + 4);
    @(negedge clk);
    start_stop = 1'b0;
    tick_to(a + 5);
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    lap_reset = 1'b1;
    expect_ev(K_CLR, cyc + 1);
    @(negedge clk);
    lap_reset = 1'b0;

    repeat (4) @(negedge clk);
    chk("expected_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
